// File: rtl/pn_descrambler_par_if.sv
// Beat bus of the parallel PN descrambler: scrambled input beat with seed control,
// and the descrambled output beat with framing flags.
interface pn_descrambler_par_if #(
    parameter int DATA_W = 1,
    parameter int LFSR_W = 12
);
    logic              isop;
    logic              ival;
    logic [DATA_W-1:0] idat;
    logic              iseed_load;
    logic [LFSR_W-1:0] iseed;
    logic              ibypass;
    logic              oval;
    logic              osop;
    logic              oeop;
    logic [DATA_W-1:0] odat;
    logic              oerr;

    modport master (
        output isop, ival, idat, iseed_load, iseed, ibypass,
        input  oval, osop, oeop, odat, oerr
    );

    modport slave (
        input  isop, ival, idat, iseed_load, iseed, ibypass,
        output oval, osop, oeop, odat, oerr
    );
endinterface

// File: rtl/pn_descrambler_par.sv
// Parallel LFSR descrambler for the DeFEC receive path (additive or self-synchronising),
// with packet framing, end-of-packet generation and framing-error pulses, one registered cycle of latency.
module pn_descrambler_par #(
    parameter int                LFSR_W      = 12,
    parameter logic [LFSR_W-1:0] POLY        = 12'h829,
    parameter logic [LFSR_W-1:0] SEED        = 12'hFFF,
    parameter int                DATA_W      = 1,
    parameter int                MODE        = 0,
    parameter int                PACK_LEN    = 1904,
    parameter int                AUTO_RESEED = 0
) (
    input logic                 iclk,
    input logic                 ireset,
    pn_descrambler_par_if.slave bus
);
    localparam int               BEATS       = PACK_LEN / DATA_W;
    localparam int               LAST        = BEATS - 32'sd1;
    localparam int               CNT_W       = (BEATS > 32'sd1) ? $clog2(BEATS) : 32'sd1;
    localparam logic [CNT_W-1:0] LAST_C      = CNT_W'(LAST);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(32'sd1);
    localparam bit               SELF_SYNC   = (MODE == 32'sd1);
    localparam bit               AUTO        = (AUTO_RESEED != 32'sd0);
    localparam bit               SINGLE_BEAT = (LAST == 32'sd0);

    if (((PACK_LEN % DATA_W) != 32'sd0) || (DATA_W < 32'sd1) || (DATA_W > 32'sd64) ||
        (LFSR_W < 32'sd2) || (LFSR_W > 32'sd32)) begin : g_bad_cfg
        $error("pn_descrambler_par: PACK_LEN must be a multiple of DATA_W, DATA_W in 1..64, LFSR_W in 2..32");
    end

    function automatic logic lfsr_fb(input logic [LFSR_W-1:0] s);
        return ^(s & POLY);
    endfunction

    logic [LFSR_W-1:0] r_lfsr;
    logic [LFSR_W-1:0] r_seed;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_active;
    logic              r_seen;
    logic              r_oval;
    logic              r_osop;
    logic              r_oeop;
    logic              r_oerr;
    logic [DATA_W-1:0] r_odat;

    logic              w_sop;
    logic              w_at_last;
    logic              w_eop;
    logic              w_err;
    logic [LFSR_W-1:0] w_eff_seed;
    logic [LFSR_W-1:0] w_s;
    logic              w_fb;
    logic [DATA_W-1:0] w_desc;

    // Framing decode and DATA_W chained serial descrambler steps, first-in-time bit at the MSB.
    always_comb begin
        w_sop      = bus.ival && (bus.isop || (AUTO && !r_active));
        w_at_last  = r_active && (r_cnt == LAST_C);
        w_eff_seed = bus.iseed_load ? bus.iseed : r_seed;
        w_s        = (!SELF_SYNC && w_sop) ? w_eff_seed : r_lfsr;
        w_fb       = 1'b0;
        w_desc     = '0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            w_fb      = lfsr_fb(w_s);
            w_desc[i] = bus.idat[i] ^ w_fb;
            w_s       = SELF_SYNC ? {w_s[LFSR_W-2:0], bus.idat[i]} : {w_s[LFSR_W-2:0], w_fb};
        end
        if (!bus.ival) begin
            w_eop = 1'b0;
            w_err = 1'b0;
        end else if (w_sop) begin
            // An explicit SOP inside a packet is early; an implicit one errs only before any packet.
            w_eop = SINGLE_BEAT;
            w_err = bus.isop ? r_active : !r_seen;
        end else if (r_active) begin
            w_eop = w_at_last;
            w_err = 1'b0;
        end else begin
            w_eop = 1'b0;
            w_err = 1'b1;
        end
    end

    // LFSR, seed, packet counter and registered outputs.
    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            r_lfsr   <= SEED;
            r_seed   <= SEED;
            r_cnt    <= '0;
            r_active <= 1'b0;
            r_seen   <= 1'b0;
            r_oval   <= 1'b0;
            r_osop   <= 1'b0;
            r_oeop   <= 1'b0;
            r_oerr   <= 1'b0;
            r_odat   <= '0;
        end else begin
            if (bus.iseed_load) begin
                r_seed <= bus.iseed;
            end
            if (bus.ival) begin
                r_lfsr <= w_s;
                r_odat <= bus.ibypass ? bus.idat : w_desc;
                if (w_sop) begin
                    r_active <= !SINGLE_BEAT;
                    r_cnt    <= SINGLE_BEAT ? '0 : CNT_ONE;
                    r_seen   <= 1'b1;
                end else if (w_at_last) begin
                    r_active <= 1'b0;
                    r_cnt    <= '0;
                end else if (r_active) begin
                    r_cnt <= r_cnt + CNT_ONE;
                end
            end
            r_oval <= bus.ival;
            r_osop <= w_sop;
            r_oeop <= w_eop;
            r_oerr <= w_err;
        end
    end

    assign bus.oval = r_oval;
    assign bus.osop = r_osop;
    assign bus.oeop = r_oeop;
    assign bus.oerr = r_oerr;
    assign bus.odat = r_odat;
endmodule

// File: tb/tb_pn_descrambler_par.sv
// Directed bench for pn_descrambler_par: additive 8-bit, self-sync 8-bit and additive 4-bit
// short-packet instances, checked against hand values and a serial scrambler model.
module tb_pn_descrambler_par;
    localparam logic [11:0] POLY = 12'h829;

    logic iclk   = 1'b0;
    logic ireset = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    logic [11:0] ms;
    logic [11:0] m_seed;
    logic [11:0] st;
    logic [7:0]  plain;
    logic [7:0]  cd;

    pn_descrambler_par_if #(.DATA_W(8), .LFSR_W(12)) a_if ();
    pn_descrambler_par_if #(.DATA_W(8), .LFSR_W(12)) b_if ();
    pn_descrambler_par_if #(.DATA_W(4), .LFSR_W(12)) c_if ();

    pn_descrambler_par #(.DATA_W(8), .MODE(0), .PACK_LEN(1904), .AUTO_RESEED(0)) u_a (
        .iclk(iclk), .ireset(ireset), .bus(a_if.slave));
    pn_descrambler_par #(.DATA_W(8), .MODE(1), .PACK_LEN(1904), .AUTO_RESEED(0)) u_b (
        .iclk(iclk), .ireset(ireset), .bus(b_if.slave));
    pn_descrambler_par #(.DATA_W(4), .MODE(0), .PACK_LEN(8), .AUTO_RESEED(1)) u_c (
        .iclk(iclk), .ireset(ireset), .bus(c_if.slave));

    always #5 iclk = ~iclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Additive keystream, 8 bits MSB first.
    function automatic logic [7:0] ks8(input logic [11:0] s_in, output logic [11:0] s_out);
        logic [11:0] s;
        logic [7:0]  k;
        logic        fb;
        s = s_in;
        k = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            fb   = ^(s & POLY);
            k[i] = fb;
            s    = {s[10:0], fb};
        end
        s_out = s;
        return k;
    endfunction

    // Self-synchronising scrambler: transmitted bits are shifted into the state.
    function automatic logic [7:0] ss8(input logic [7:0] p, input logic [11:0] s_in, output logic [11:0] s_out);
        logic [11:0] s;
        logic [7:0]  c;
        s = s_in;
        c = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            c[i] = p[i] ^ (^(s & POLY));
            s    = {s[10:0], c[i]};
        end
        s_out = s;
        return c;
    endfunction

    task automatic idle();
        a_if.ival = 1'b0; b_if.ival = 1'b0; c_if.ival = 1'b0;
        @(posedge iclk);
        #1;
    endtask

    task automatic beat_a(input logic sop, input logic [7:0] d, input logic byp, input logic load, input logic [11:0] seed);
        a_if.isop = sop; a_if.ival = 1'b1; a_if.idat = d; a_if.ibypass = byp;
        a_if.iseed_load = load; a_if.iseed = seed;
        @(posedge iclk);
        #1;
        a_if.isop = 1'b0; a_if.ival = 1'b0; a_if.ibypass = 1'b0; a_if.iseed_load = 1'b0;
    endtask

    task automatic beat_b(input logic sop, input logic [7:0] d, input logic byp);
        b_if.isop = sop; b_if.ival = 1'b1; b_if.idat = d; b_if.ibypass = byp;
        @(posedge iclk);
        #1;
        b_if.isop = 1'b0; b_if.ival = 1'b0; b_if.ibypass = 1'b0;
    endtask

    task automatic beat_c(input logic sop, input logic [3:0] d);
        c_if.isop = sop; c_if.ival = 1'b1; c_if.idat = d;
        @(posedge iclk);
        #1;
        c_if.isop = 1'b0; c_if.ival = 1'b0;
    endtask

    // One additive beat of random payload scrambled by the model, then checked.
    task automatic send_a(input string tag, input logic sop, input logic byp, input logic load,
                          input logic [11:0] seed, input logic exp_eop, input logic exp_err);
        logic [7:0] p;
        logic [7:0] d;
        p = 8'($urandom);
        if (load) m_seed = seed;
        if (sop) ms = m_seed;
        d = p ^ ks8(ms, ms);
        beat_a(sop, d, byp, load, seed);
        check({tag, "_dat"}, 64'(a_if.odat), 64'(byp ? d : p));
        check({tag, "_flg"}, 64'({a_if.oval, a_if.osop, a_if.oeop, a_if.oerr}),
              64'({1'b1, sop, exp_eop, exp_err}));
    endtask

    initial begin
        a_if.isop = 1'b0; a_if.ival = 1'b0; a_if.idat = 8'h00; a_if.iseed_load = 1'b0; a_if.iseed = 12'h000; a_if.ibypass = 1'b0;
        b_if.isop = 1'b0; b_if.ival = 1'b0; b_if.idat = 8'h00; b_if.iseed_load = 1'b0; b_if.iseed = 12'h000; b_if.ibypass = 1'b0;
        c_if.isop = 1'b0; c_if.ival = 1'b0; c_if.idat = 4'h0; c_if.iseed_load = 1'b0; c_if.iseed = 12'h000; c_if.ibypass = 1'b0;
        m_seed = 12'hFFF;
        ms     = 12'hFFF;

        #2 ireset = 1'b0;
        repeat (3) @(posedge iclk);
        #1;
        check("rst_a_flg", 64'({a_if.oval, a_if.osop, a_if.oeop, a_if.oerr}), 64'(4'b0000));
        check("rst_a_dat", 64'(a_if.odat), 64'(8'h00));
        check("rst_c_flg", 64'({c_if.oval, c_if.osop, c_if.oeop, c_if.oerr}), 64'(4'b0000));
        check("rst_c_lfsr", 64'(u_c.r_lfsr), 64'(12'hFFF));
        ireset = 1'b1;
        @(posedge iclk);
        #1;

        // 4-bit, 2-beat packets with auto reseed: first beat is implicit SOP before any packet.
        beat_c(1'b0, 4'h0);
        check("c_imp0_dat", 64'(c_if.odat), 64'(4'h5));
        check("c_imp0_flg", 64'({c_if.oval, c_if.osop, c_if.oeop, c_if.oerr}), 64'(4'b1101));
        beat_c(1'b0, 4'h0);
        check("c_imp1_dat", 64'(c_if.odat), 64'(4'hA));
        check("c_imp1_flg", 64'({c_if.oval, c_if.osop, c_if.oeop, c_if.oerr}), 64'(4'b1010));
        beat_c(1'b1, 4'h0);
        check("c_sop_dat", 64'(c_if.odat), 64'(4'h5));
        check("c_sop_flg", 64'({c_if.oval, c_if.osop, c_if.oeop, c_if.oerr}), 64'(4'b1100));
        check("c_sop_lfsr", 64'(u_c.r_lfsr), 64'(12'hFF5));
        idle();
        check("c_gap_flg", 64'({c_if.oval, c_if.osop, c_if.oeop, c_if.oerr}), 64'(4'b0000));
        check("c_gap_lfsr", 64'(u_c.r_lfsr), 64'(12'hFF5));
        beat_c(1'b0, 4'h0);
        check("c_b2_dat", 64'(c_if.odat), 64'(4'hA));
        check("c_b2_flg", 64'({c_if.oval, c_if.osop, c_if.oeop, c_if.oerr}), 64'(4'b1010));
        beat_c(1'b0, 4'h0);
        check("c_imp2_dat", 64'(c_if.odat), 64'(4'h5));
        check("c_imp2_flg", 64'({c_if.oval, c_if.osop, c_if.oeop, c_if.oerr}), 64'(4'b1100));

        // Additive 8-bit: beat with no packet open continues from SEED and flags an error.
        beat_a(1'b0, 8'h00, 1'b0, 1'b0, 12'h000);
        check("a_over0_dat", 64'(a_if.odat), 64'(8'h5A));
        check("a_over0_flg", 64'({a_if.oval, a_if.osop, a_if.oeop, a_if.oerr}), 64'(4'b1001));
        ms = u_a.r_lfsr;

        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 238; k++) begin
                if ((k % 60) == 30) begin
                    idle();
                    check("a_gap_flg", 64'({a_if.oval, a_if.osop, a_if.oeop, a_if.oerr}), 64'(4'b0000));
                end
                send_a($sformatf("a_p%0d_b%0d", p, k), k == 0, (p == 0) && (k >= 10) && (k < 15),
                       1'b0, 12'h000, k == 237, 1'b0);
            end
        end
        send_a("a_overlong", 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1);

        for (int k = 0; k < 100; k++)
            send_a($sformatf("a_early_b%0d", k), (k == 0) || (k == 99), 1'b0, 1'b0, 12'h000, 1'b0, k == 99);
        for (int k = 1; k < 238; k++)
            send_a($sformatf("a_restart_b%0d", k), 1'b0, 1'b0, 1'b0, 12'h000, k == 237, 1'b0);

        for (int k = 0; k < 237; k++)
            send_a($sformatf("a_full_b%0d", k), k == 0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
        send_a("a_sop_at_last", 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1);
        for (int k = 1; k < 238; k++)
            send_a($sformatf("a_after_b%0d", k), 1'b0, 1'b0, 1'b0, 12'h000, k == 237, 1'b0);

        send_a("a_seed_sop", 1'b1, 1'b0, 1'b1, 12'h001, 1'b0, 1'b0);
        for (int k = 1; k < 4; k++)
            send_a($sformatf("a_seed_b%0d", k), 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
        send_a("a_seed_resop", 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1);
        for (int k = 1; k < 4; k++)
            send_a($sformatf("a_reseed_b%0d", k), 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);

        // Asynchronous reset mid-packet clears outputs at once and restores SEED.
        ireset = 1'b0;
        #2;
        check("a_midrst_flg", 64'({a_if.oval, a_if.osop, a_if.oeop, a_if.oerr}), 64'(4'b0000));
        check("a_midrst_dat", 64'(a_if.odat), 64'(8'h00));
        @(posedge iclk);
        #1;
        ireset = 1'b1;
        m_seed = 12'hFFF;
        beat_a(1'b0, 8'h00, 1'b0, 1'b0, 12'h000);
        check("a_post_rst_dat", 64'(a_if.odat), 64'(8'h5A));
        check("a_post_rst_flg", 64'({a_if.oval, a_if.osop, a_if.oeop, a_if.oerr}), 64'(4'b1001));
        beat_a(1'b1, 8'h00, 1'b0, 1'b0, 12'h000);
        check("a_post_rst_sop_dat", 64'(a_if.odat), 64'(8'h5A));
        check("a_post_rst_sop_flg", 64'({a_if.oval, a_if.osop, a_if.oeop, a_if.oerr}), 64'(4'b1100));

        // Self-sync 8-bit: transmitter starts from a state unrelated to the receiver seed.
        st = 12'h5A3;
        for (int k = 0; k < 20; k++) begin
            plain = 8'($urandom);
            cd    = ss8(plain, st, st);
            beat_b(k == 0, cd, (k >= 10) && (k < 15));
            if ((k >= 10) && (k < 15))
                check($sformatf("b_byp_b%0d", k), 64'(b_if.odat), 64'(cd));
            else if (k >= 2)
                check($sformatf("b_dat_b%0d", k), 64'(b_if.odat), 64'(plain));
            check($sformatf("b_flg_b%0d", k), 64'({b_if.oval, b_if.osop, b_if.oeop, b_if.oerr}),
                  64'({1'b1, k == 0, 1'b0, 1'b0}));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
